spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
SPI mode-0 master transfer controller. It sequences one DATA_W-bit full-duplex transfer per start request, and its timing is paced entirely by the single-cycle spi_clk_en tick from the SPI clock divider. It drives CS_n, SCLK and MOSI, samples MISO, and returns the received word with a done pulse. It sits between the UART-side command logic and the SPI pins.

Parameters:
DATA_W, 8, transfer word width in bits (legal range 2..32).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
spi_clk_en  input  1  one-clk-wide pacing tick from the clock divider; may be high on consecutive cycles.
start  input  1  transfer request; accepted only when busy=0.
tx_data  input  DATA_W  word to send, MSB first; sampled only in the cycle start is accepted.
miso  input  1  serial data from the slave; already synchronised upstream.
sclk  output  1  SPI clock, idle low (CPOL=0).
mosi  output  1  serial data to the slave.
cs_n  output  1  active-low slave select.
busy  output  1  high from the cycle after acceptance until the done cycle.
done  output  1  one-clk pulse when the transfer completes.
rx_data  output  DATA_W  received word; valid from the done cycle and held until the next done.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, sclk=0, mosi=0, cs_n=1, busy=0, done=0, rx_data=0, bit_cnt=0, both shift registers cleared. Reset asserted mid-transfer aborts the transfer: cs_n rises immediately and no done pulse is produced.
- States: IDLE, SETUP, XFER, HOLD.
- IDLE:
  - spi_clk_en is ignored.
  - If start=1: tx_shift<=tx_data; mosi<=tx_data[DATA_W-1]; cs_n<=0; busy<=1; bit_cnt<=0; go to SETUP.
- SETUP: on a tick, go to XFER. Outputs do not change. This gives one tick of CS-to-first-edge setup time.
- XFER, on each tick:
  - If sclk=0 (rising edge): sclk<=1; rx_shift<={rx_shift[DATA_W-2:0], miso}.
  - If sclk=1 and bit_cnt<DATA_W-1 (falling edge): sclk<=0; bit_cnt<=bit_cnt+1; shift tx_shift left; mosi<=next bit.
  - If sclk=1 and bit_cnt=DATA_W-1 (falling edge): sclk<=0; mosi<=0; go to HOLD.
- HOLD: on a tick, cs_n<=1; rx_data<=rx_shift; done<=1 for exactly one clk; busy<=0; go to IDLE.
- Ticks absent: every state holds and all outputs stay stable. There is no timeout.
- Timing: one transfer takes exactly 2*DATA_W+2 ticks from the first tick after acceptance to the done cycle.
- SCLK shape: DATA_W rising edges, 50% duty in tick units. MOSI changes only on falling edges or at acceptance. MISO is sampled only on rising edges.
- start while busy=1 is ignored, with no queuing; tx_data is not re-sampled.
- The done cycle is in IDLE with busy=0. A start in that same cycle is accepted, so back-to-back transfers have CS_n high for only one clk.
- A tick in the same cycle as an accepted start is ignored, because the state is IDLE.
- spi_clk_en held high permanently is legal: the transfer then advances one step per clk.

Test Plan:
1. DATA_W=8, tick every 4 clk, miso looped to mosi, start with tx_data=0xA5 -> mosi shows 1,0,1,0,0,1,0,1 across 8 sclk pulses; done exactly 18 ticks after acceptance; rx_data=0xA5; cs_n low throughout and high in the done cycle.
2. miso tied to 1, tx_data=0x00 -> mosi stays 0; rx_data=0xFF; exactly 8 sclk rising edges counted.
3. start pulsed again mid-transfer with tx_data=0x3C -> ignored; first transfer completes unchanged; exactly one done pulse.
4. start held high through the done cycle -> second transfer accepted in the done cycle; cs_n high for exactly one clk between transfers; both rx_data values correct.
5. rst_n asserted after the 3rd sclk rising edge -> cs_n=1, sclk=0 and busy=0 immediately; no done pulse; a new transfer after reset completes normally.
6. spi_clk_en held at constant 1 with tx_data=0x81 -> done 18 clk after the acceptance cycle; sclk period is 2 clk; rx_data correct with loopback.

Source files
------------

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_ctrl
// Description : SPI mode-0 master transfer controller, paced by spi_clk_en.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk_en,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic              sclk_q,     sclk_d;
    logic              mosi_q,     mosi_d;
    logic              cs_n_q,     cs_n_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [DATA_W-1:0] rx_data_q,  rx_data_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rx_data_d  = rx_data_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_shift_d = tx_data;
                    mosi_d     = tx_data[DATA_W-1];
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (spi_clk_en) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (spi_clk_en) begin
                    if (!sclk_q) begin
                        sclk_d     = 1'b1;
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
                    end else if (bit_cnt_q != C_LAST_BIT) begin
                        sclk_d     = 1'b0;
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        // Rotating keeps every bit live; the wrapped MSB is never driven out.
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], tx_shift_q[DATA_W-1]};
                        mosi_d     = tx_shift_q[DATA_W-2];
                    end else begin
                        sclk_d  = 1'b0;
                        mosi_d  = 1'b0;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (spi_clk_en) begin
                    cs_n_d    = 1'b1;
                    rx_data_d = rx_shift_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_ctrl
// Description : Scoreboard bench for spi_master_ctrl, directed transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;

    localparam int DATA_W  = 8;
    localparam int C_TICKS = 2 * DATA_W + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              spi_clk_en;
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              miso;
    logic              sclk, mosi, cs_n, busy, done;
    logic [DATA_W-1:0] rx_data;

    typedef struct {
        logic [DATA_W-1:0] tx;
        logic [DATA_W-1:0] rx;
    } exp_t;
    exp_t exp_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int tick_div = 4;
    int miso_mode = 0;
    int tdiv_cnt = 0;
    int tick_cnt, busy_cyc, rise_cnt, since_rise, done_seen;
    logic cs_ok, prev_busy, prev_sclk;
    logic [DATA_W-1:0] mosi_cap;

    assign miso = (miso_mode == 0) ? mosi : 1'b1;

    spi_master_ctrl #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk_en(spi_clk_en), .start(start),
        .tx_data(tx_data), .miso(miso), .sclk(sclk), .mosi(mosi),
        .cs_n(cs_n), .busy(busy), .done(done), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Tick source: changes 2ns after the rising edge so the DUT sees a stable level.
    initial begin
        spi_clk_en = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tdiv_cnt   = (tdiv_cnt + 1 >= tick_div) ? 0 : tdiv_cnt + 1;
            spi_clk_en = (tdiv_cnt == 0);
        end
    end

    // Monitor: observes pins at the falling edge and scores every done pulse.
    initial begin
        done_seen = 0;
        prev_busy = 1'b0;
        prev_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                prev_sclk = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    tick_cnt = 0; busy_cyc = 0; rise_cnt = 0;
                    since_rise = 0; mosi_cap = '0; cs_ok = 1'b1;
                end
                if (busy) begin
                    busy_cyc++;
                    if (spi_clk_en) tick_cnt++;
                    if (cs_n) cs_ok = 1'b0;
                end
                since_rise++;
                if (sclk && !prev_sclk) begin
                    if (rise_cnt > 0) check("sclk_period", since_rise, 2 * tick_div);
                    since_rise = 0;
                    rise_cnt++;
                    mosi_cap = {mosi_cap[DATA_W-2:0], mosi};
                end
                if (done) begin
                    done_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("rx_data", rx_data, e.rx);
                        check("mosi_bits", mosi_cap, e.tx);
                        check("sclk_rises", rise_cnt, DATA_W);
                        check("tick_count", tick_cnt, C_TICKS);
                        if (tick_div == 1) check("clk_latency", busy_cyc, C_TICKS);
                        check("cs_low_during", cs_ok, 1);
                        check("done_cs_busy", {cs_n, busy}, 2'b10);
                    end
                end
                prev_busy = busy;
                prev_sclk = sclk;
            end
        end
    end

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic start_xfer(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] rx);
        exp_t e;
        @(negedge clk);
        start   = 1'b1;
        tx_data = tx;
        e.tx = tx; e.rx = rx;
        exp_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        tx_data = '0;
    endtask

    initial begin
        exp_t e;
        int   seen;
        rst_n = 1'b0; start = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", {sclk, mosi, cs_n, busy, done}, 5'b00100);
        check("reset_rx", rx_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: loopback 0xA5
        start_xfer(8'hA5, 8'hA5);
        wait_done(400);

        // 2: miso high, tx all zero
        miso_mode = 1;
        start_xfer(8'h00, 8'hFF);
        wait_done(400);
        miso_mode = 0;

        // 3: start while busy is ignored
        start_xfer(8'h5A, 8'h5A);
        for (int i = 0; i < 400 && rise_cnt < 2; i++) @(negedge clk);
        start = 1'b1; tx_data = 8'h3C;
        @(negedge clk);
        start = 1'b0; tx_data = '0;
        wait_done(400);
        repeat (10) @(negedge clk);

        // 4: start held through done, back-to-back
        @(negedge clk);
        start = 1'b1; tx_data = 8'h96;
        e.tx = 8'h96; e.rx = 8'h96; exp_q.push_back(e);
        @(negedge clk);
        tx_data = 8'h69;
        e.tx = 8'h69; e.rx = 8'h69; exp_q.push_back(e);
        wait_done(400);
        @(negedge clk);
        check("b2b_reaccept", {cs_n, busy}, 2'b01);
        start = 1'b0; tx_data = '0;
        wait_done(400);

        // 5: reset after third rising sclk edge
        start_xfer(8'hC3, 8'hC3);
        for (int i = 0; i < 400 && rise_cnt < 3; i++) @(negedge clk);
        check("third_rise_seen", rise_cnt, 3);
        #2 rst_n = 1'b0;
        #1 check("abort_outs", {cs_n, sclk, busy}, 3'b100);
        void'(exp_q.pop_back());
        seen = done_seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("no_done_after_abort", done_seen, seen);
        start_xfer(8'hE7, 8'hE7);
        wait_done(400);

        // 6: tick permanently high
        tick_div = 1;
        repeat (2) @(negedge clk);
        start_xfer(8'h81, 8'h81);
        wait_done(100);
        repeat (5) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_seen, 7);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
